// File: rtl/if_fetch_unit.sv
// Instruction fetch unit: keeps at most one memory read in flight, queues returned words
// in a small FIFO for decode, and flushes and refetches on a redirect.
module if_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        CLK,
    input  logic        RESET,
    output logic        IMEM_REQ,
    output logic [31:0] IMEM_ADDR,
    input  logic        IMEM_READY,
    input  logic [31:0] IMEM_RDATA,
    input  logic        REDIRECT,
    input  logic [31:0] REDIRECT_PC,
    input  logic        STALL,
    output logic        INSTR_VALID,
    output logic [31:0] INSTR,
    output logic [31:0] PC_OUT
);

    localparam int                PTR_W      = $clog2(BUF_DEPTH);
    localparam int                CNT_W      = $clog2(BUF_DEPTH + 1);
    localparam logic [CNT_W-1:0]  DEPTH_C    = CNT_W'(BUF_DEPTH);
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
    localparam logic [PTR_W-1:0]  PTR_ONE    = PTR_W'(1);
    localparam logic [31:0]       RESET_PC_C = {RESET_PC[31:2], 2'b00};

    typedef enum logic {
        ST_FETCH,
        ST_DISCARD
    } state_e;

    state_e           state_q, state_d;
    logic             req_q, req_d;
    logic [31:0]      addr_q, addr_d;
    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;

    logic [31:0]      buf_pc_q    [BUF_DEPTH];
    logic [31:0]      buf_instr_q [BUF_DEPTH];

    logic             accept;
    logic             push;
    logic             pop;
    logic             buf_empty;
    logic [31:0]      redirect_target;
    logic             redirect_pc_unused;

    // A response only counts when our own request was up; READY alone means nothing.
    assign accept          = req_q & IMEM_READY;
    assign buf_empty       = (count_q == '0);
    assign push            = accept & (state_q == ST_FETCH) & ~REDIRECT;
    assign pop             = ~buf_empty & ~STALL & ~REDIRECT;
    assign redirect_target = {REDIRECT_PC[31:2], 2'b00};
    assign redirect_pc_unused = ^REDIRECT_PC[1:0];

    always_comb begin
        // NOTE: every variable gets a default first so no path through this block infers a latch.
        state_d    = state_q;
        req_d      = req_q;
        addr_d     = addr_q;
        fetch_pc_d = fetch_pc_q;
        count_d    = count_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;

        if (REDIRECT) begin
            count_d    = '0;
            rd_ptr_d   = '0;
            wr_ptr_d   = '0;
            fetch_pc_d = redirect_target;
            req_d      = 1'b1;
            if (req_q && !IMEM_READY) begin
                // Old request still on the bus: keep its address and swallow its reply later.
                state_d = ST_DISCARD;
            end else begin
                state_d = ST_FETCH;
                addr_d  = redirect_target;
            end
        end else begin
            if (state_q == ST_DISCARD && accept) begin
                state_d = ST_FETCH;
            end
            if (push) begin
                wr_ptr_d   = wr_ptr_q + PTR_ONE;
                fetch_pc_d = fetch_pc_q + 32'd4;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_ONE;
                2'b01:   count_d = count_q - CNT_ONE;
                default: count_d = count_q;
            endcase
            // Hold an unanswered request; otherwise ask only if a slot is free after this edge.
            if (!(req_q && !IMEM_READY)) begin
                req_d  = (count_d < DEPTH_C);
                addr_d = fetch_pc_d;
            end
        end
    end

    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q    <= ST_FETCH;
            req_q      <= 1'b0;
            addr_q     <= RESET_PC_C;
            fetch_pc_q <= RESET_PC_C;
            count_q    <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples the pre-edge values.
            state_q    <= state_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            fetch_pc_q <= fetch_pc_d;
            count_q    <= count_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
        end
    end

    // NOTE: buffer storage is deliberately not reset; the outputs are masked whenever it is empty.
    always_ff @(posedge CLK) begin
        if (push) begin
            buf_pc_q[wr_ptr_q]    <= addr_q;
            buf_instr_q[wr_ptr_q] <= IMEM_RDATA;
        end
    end

    assign IMEM_REQ    = req_q;
    assign IMEM_ADDR   = addr_q;
    assign INSTR_VALID = ~buf_empty;
    assign INSTR       = buf_empty ? 32'h0 : buf_instr_q[rd_ptr_q];
    assign PC_OUT      = buf_empty ? 32'h0 : buf_pc_q[rd_ptr_q];

    a_count_bound: assert property (@(posedge CLK) disable iff (!RESET)
        count_q <= DEPTH_C);

    a_req_hold: assert property (@(posedge CLK) disable iff (!RESET)
        (IMEM_REQ && !IMEM_READY) |=> (IMEM_REQ && $stable(IMEM_ADDR)));

    a_discard_req: assert property (@(posedge CLK) disable iff (!RESET)
        (state_q == ST_DISCARD) |-> IMEM_REQ);

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: directed scenarios with literal checks, plus a queue-based
// model of the instruction stream compared against the DUT on every falling clock edge.
module tb_if_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int          DEPTH  = 2;

    logic        clk;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] pc_out;

    int n_tests = 0;
    int n_fail  = 0;

    if_fetch_unit #(
        .RESET_PC  (RST_PC),
        .BUF_DEPTH (DEPTH)
    ) dut (
        .CLK         (clk),
        .RESET       (rst_n),
        .IMEM_REQ    (imem_req),
        .IMEM_ADDR   (imem_addr),
        .IMEM_READY  (imem_ready),
        .IMEM_RDATA  (imem_rdata),
        .REDIRECT    (redirect),
        .REDIRECT_PC (redirect_pc),
        .STALL       (stall),
        .INSTR_VALID (instr_valid),
        .INSTR       (instr),
        .PC_OUT      (pc_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h, expected %08h", name, act, exp);
        end
    endtask

    // Advance past the next rising edge; memory returns addr+0x13 for whatever is on the bus.
    task automatic tick();
        @(posedge clk);
        #1;
        imem_rdata = imem_addr + 32'h13;
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } entry_t;

    entry_t      mq[$];
    logic [31:0] m_next_pc  = RST_PC;
    logic        m_started  = 1'b0;
    logic        m_discard  = 1'b0;
    logic        m_hold     = 1'b0;
    logic [31:0] m_hold_adr = 32'h0;
    logic        m_req;

    always @(negedge clk) begin
        if (!rst_n) begin
            check("rst_imem_req", 32'(imem_req), 32'd0);
            check("rst_instr_valid", 32'(instr_valid), 32'd0);
            check("rst_instr", instr, 32'h0);
            check("rst_pc_out", pc_out, 32'h0);
            mq.delete();
            m_next_pc = RST_PC;
            m_started = 1'b0;
            m_discard = 1'b0;
            m_hold    = 1'b0;
        end else begin
            m_req = m_started && (m_discard || mq.size() < DEPTH);
            check("mdl_imem_req", 32'(imem_req), 32'(m_req));
            if (m_hold) check("mdl_addr_held", imem_addr, m_hold_adr);
            if (m_req && !m_discard) check("mdl_imem_addr", imem_addr, m_next_pc);
            check("mdl_instr_valid", 32'(instr_valid), 32'(mq.size() > 0));
            if (mq.size() > 0) begin
                check("mdl_pc_out", pc_out, mq[0].pc);
                check("mdl_instr", instr, mq[0].instr);
            end

            // What the next rising edge must do, given the inputs now on the pins.
            m_hold     = m_req && !imem_ready;
            m_hold_adr = imem_addr;
            if (redirect) begin
                mq.delete();
                m_next_pc = {redirect_pc[31:2], 2'b00};
                m_discard = m_req && !imem_ready;
            end else begin
                if (mq.size() > 0 && !stall) void'(mq.pop_front());
                if (m_req && imem_ready) begin
                    if (m_discard) begin
                        m_discard = 1'b0;
                    end else begin
                        mq.push_back('{pc: m_next_pc, instr: m_next_pc + 32'h13});
                        m_next_pc = m_next_pc + 32'd4;
                    end
                end
            end
            m_started = 1'b1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d", n_tests);
        $fatal(1);
    end

    // ---------------- directed stimulus ----------------
    initial begin
        logic found;
        rst_n       = 1'b1;
        imem_ready  = 1'b0;
        imem_rdata  = 32'h0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        stall       = 1'b0;
        #1 rst_n = 1'b0;
        tick();
        tick();
        check("reset_req", 32'(imem_req), 32'd0);
        check("reset_valid", 32'(instr_valid), 32'd0);
        check("reset_instr", instr, 32'h0);
        check("reset_pc_out", pc_out, 32'h0);

        // Zero-wait stream
        rst_n      = 1'b1;
        imem_ready = 1'b1;
        tick();
        check("first_req", 32'(imem_req), 32'd1);
        check("first_addr", imem_addr, RST_PC);
        check("first_valid", 32'(instr_valid), 32'd0);
        tick();
        check("zw_valid0", 32'(instr_valid), 32'd1);
        check("zw_pc0", pc_out, 32'h0);
        check("zw_instr0", instr, 32'h13);
        tick();
        check("zw_pc4", pc_out, 32'h4);
        check("zw_instr4", instr, 32'h17);
        tick();
        check("zw_pc8", pc_out, 32'h8);
        check("zw_instr8", instr, 32'h1B);

        // Backpressure with the buffer filling to depth 2
        stall = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("stall_pc_hold", pc_out, 32'h8);
            check("stall_req_low", 32'(imem_req), 32'd0);
        end
        stall = 1'b0;
        tick();
        check("release_pc", pc_out, 32'hC);
        check("release_instr", instr, 32'h1F);
        tick();
        check("release_pc2", pc_out, 32'h10);

        // Asynchronous reset between edges
        #2 rst_n = 1'b0;
        #1;
        check("async_req", 32'(imem_req), 32'd0);
        check("async_valid", 32'(instr_valid), 32'd0);
        check("async_instr", instr, 32'h0);
        check("async_pc_out", pc_out, 32'h0);
        tick();
        tick();
        rst_n      = 1'b1;
        imem_ready = 1'b0;
        tick();
        check("rerelease_req", 32'(imem_req), 32'd1);
        check("rerelease_addr", imem_addr, RST_PC);

        // Wait states: READY every third cycle until the 0x10 request is on the bus
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (imem_req && imem_addr == 32'h10) begin
                found = 1'b1;
                break;
            end
            imem_ready = (i % 3 == 2);
            tick();
        end
        check("reach_req_0x10", 32'(found), 32'd1);

        // Redirect while 0x10 is pending, then retarget during the discard
        imem_ready  = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        tick();
        check("disc_valid", 32'(instr_valid), 32'd0);
        check("disc_req", 32'(imem_req), 32'd1);
        check("disc_addr", imem_addr, 32'h10);
        redirect_pc = 32'h42;
        tick();
        check("disc2_addr", imem_addr, 32'h10);
        redirect = 1'b0;
        tick();
        check("disc3_addr", imem_addr, 32'h10);
        imem_ready = 1'b1;
        tick();
        check("after_drop_addr", imem_addr, 32'h40);
        check("after_drop_valid", 32'(instr_valid), 32'd0);
        tick();
        check("redir_pc", pc_out, 32'h40);
        check("redir_instr", instr, 32'h53);
        tick();
        check("redir_pc2", pc_out, 32'h44);

        // Redirect in the same cycle as READY
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        tick();
        redirect = 1'b0;
        check("rr_valid", 32'(instr_valid), 32'd0);
        check("rr_addr", imem_addr, 32'h100);
        tick();
        check("rr_pc", pc_out, 32'h100);
        check("rr_instr", instr, 32'h113);

        // Redirect during STALL with a full buffer
        stall = 1'b1;
        tick();
        tick();
        tick();
        redirect    = 1'b1;
        redirect_pc = 32'h207;
        tick();
        redirect = 1'b0;
        stall    = 1'b0;
        check("rs_valid", 32'(instr_valid), 32'd0);
        check("rs_addr", imem_addr, 32'h204);
        check("rs_req", 32'(imem_req), 32'd1);
        tick();
        check("rs_pc", pc_out, 32'h204);
        check("rs_instr", instr, 32'h217);

        // Fetch PC wrap at the top of the address space
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFF8;
        tick();
        redirect = 1'b0;
        tick();
        check("wrap_pc_f8", pc_out, 32'hFFFF_FFF8);
        tick();
        check("wrap_pc_fc", pc_out, 32'hFFFF_FFFC);
        tick();
        check("wrap_pc_0", pc_out, 32'h0);
        check("wrap_instr_0", instr, 32'h13);
        tick();
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/if_fetch_unit.md
IF_FETCH_UNIT -- requirements
Module: if_fetch_unit

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h00000000, first fetch address after reset.
REQ-002 SHALL have parameter BUF_DEPTH, default 2, fetch-buffer entries (legal values 2 or 4).
REQ-003 SHALL have port CLK  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port RESET  input  1  asynchronous, active-low reset (0 = reset).
REQ-005 SHALL have port IMEM_REQ  output  1  read request to INSTRUCTION_MEMORY.
REQ-006 SHALL have port IMEM_ADDR  output  32  word-aligned read address.
REQ-007 SHALL have port IMEM_READY  input  1  memory response valid this cycle.
REQ-008 SHALL have port IMEM_RDATA  input  32  instruction word; valid when IMEM_READY=1.
REQ-009 SHALL have port REDIRECT  input  1  branch/jump taken; flush and refetch.
REQ-010 SHALL have port REDIRECT_PC  input  32  new fetch address.
REQ-011 SHALL have port STALL  input  1  decode cannot accept an instruction this cycle.
REQ-012 SHALL have port INSTR_VALID  output  1  INSTR/PC_OUT hold a valid buffered instruction.
REQ-013 SHALL have port INSTR  output  32  head-of-buffer instruction.
REQ-014 SHALL have port PC_OUT  output  32  address of INSTR.

Function
REQ-015 SHALL implement states FETCH (normal) and DISCARD (drop one in-flight response), at most one request outstanding.
REQ-016 SHALL drive IMEM_REQ=1 in FETCH when buffer count < BUF_DEPTH, and in DISCARD unconditionally.
REQ-017 SHALL hold IMEM_REQ and IMEM_ADDR stable from assertion until the cycle IMEM_READY=1 (request accepted).
REQ-018 SHALL ignore IMEM_READY when IMEM_REQ=0.
REQ-019 SHALL, in FETCH on IMEM_REQ&IMEM_READY, push {IMEM_ADDR, IMEM_RDATA} into the buffer and advance fetch PC by 4 (modulo 2^32, 32'hFFFFFFFC wraps to 0).
REQ-020 SHALL support zero-wait memory: with READY tied high and no STALL, one instruction per cycle sustained.
REQ-021 SHALL pop the buffer head when INSTR_VALID=1 and STALL=0; push and pop in the same cycle leave count unchanged.
REQ-022 SHALL drive INSTR_VALID=1 iff buffer count > 0; INSTR/PC_OUT from registered buffer head, no combinational path from IMEM_RDATA.
REQ-023 SHALL deliver the first instruction at INSTR_VALID one cycle after the accepting IMEM_READY edge.
REQ-024 SHALL, on REDIRECT=1, flush the buffer (count=0, INSTR_VALID=0 next cycle) and set fetch PC to {REDIRECT_PC[31:2],2'b00}.
REQ-025 SHALL, on REDIRECT with a request outstanding and IMEM_READY=0, enter DISCARD; the next READY response is dropped, then FETCH resumes at the redirect PC.
REQ-026 SHALL, on REDIRECT in the same cycle as IMEM_READY, drop that response and issue the redirect address next cycle (no DISCARD).
REQ-027 SHALL, on REDIRECT during DISCARD, update the target PC and remain in DISCARD.
REQ-028 SHALL give REDIRECT priority over STALL and over push; pop is suppressed on a redirect cycle.
REQ-029 SHALL never overflow: a response is only requested when a slot is guaranteed free.

Reset
REQ-030 SHALL, while RESET=0, asynchronously force IMEM_REQ=0, INSTR_VALID=0, INSTR=0, PC_OUT=0, count=0, state=FETCH, fetch PC=RESET_PC.
REQ-031 SHALL, on the first edge after RESET rises, assert IMEM_REQ with IMEM_ADDR=RESET_PC.
REQ-032 SHALL, on reset mid-request, abandon the outstanding request and drop any later IMEM_READY until IMEM_REQ is reasserted.

Verification
REQ-033 Zero-wait stream: READY=1, RDATA=ADDR+32'h13, STALL=0 -> INSTR_VALID from cycle 2, PC_OUT 0,4,8,C... INSTR 13,17,1B,1F consecutive cycles.
REQ-034 Backpressure: STALL=1 for 5 cycles at PC 8 (depth 2) -> IMEM_REQ drops when count=2, PC_OUT holds 8, no entry lost or duplicated after release.
REQ-035 Wait states: READY asserted every 3rd cycle -> IMEM_ADDR stable during each wait, instructions in order 0,4,8 with no gaps in PC_OUT.
REQ-036 Redirect in flight: REDIRECT to 32'h00000042 while request to 0x10 pending -> 0x10 response dropped, next IMEM_ADDR 0x40, PC_OUT next valid 0x40.
REQ-037 Redirect + READY same cycle and redirect during STALL -> buffer flushed, INSTR_VALID=0 next cycle, fetch resumes at target.
REQ-038 Async reset: RESET=0 mid-stream between edges -> outputs 0 immediately; release -> IMEM_ADDR=RESET_PC on first edge.
